dmem_ctrl: RTL and testbench

Data-memory slave with wait states, on the far side of the core's data bus. It consumes `MREQ`/`WRITE`/`SIZE`/`DAD`, writes data taken from `DDT`, and returns read data on `DDT`. It completes each access with a one-cycle active-low `ACKD_n` pulse after a programmable number of wait cycles. The core stalls its M stage until that pulse arrives.

---
 rtl/dmem_ctrl_if.sv | 22 ++
 rtl/dmem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_dmem_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Core-side data bus between the M stage and the data memory.
// DDT is a bidirectional tri-state net, so it is a plain inout port on the
// controller rather than a member of this interface.
interface dmem_ctrl_if;
    logic        MREQ;
    logic        WRITE;
    logic [1:0]  SIZE;
    logic [31:0] DAD;
    logic        ACKD_n;
    logic        o_misalign;
    logic        o_range_err;

    modport master (
        output MREQ, WRITE, SIZE, DAD,
        input  ACKD_n, o_misalign, o_range_err
    );

    modport slave (
        input  MREQ, WRITE, SIZE, DAD,
        output ACKD_n, o_misalign, o_range_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory slave with a programmable number of wait states.
// A request sampled in IDLE is latched, waits WAIT_CYCLES edges, then is
// completed by a one-cycle active-low ACKD_n pulse. Stores commit at the edge
// entering ACK; load data is driven on DDT only while in ACK.
module dmem_ctrl #(
    parameter int unsigned ADDR_BITS   = 14,
    parameter logic [31:0] BASE        = 32'h0001_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus,
    inout  wire  [31:0] DDT
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] dad_q, dad_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        ack_n_q, ack_n_d;
    logic        oe_q, oe_d;
    logic        mis_q, mis_d;
    logic        rng_q, rng_d;

    logic [31:0] mem [DEPTH];

    logic [31:0]          acc_dad, acc_data, acc_off;
    logic [1:0]           acc_size;
    logic                 acc_write;
    logic                 in_range, misaligned;
    logic [ADDR_BITS-1:0] word_idx;
    logic [3:0]           lane_en;
    logic [31:0]          lane_data, mem_word, rd_data;
    logic                 enter_ack, commit;

    // Decode the current access: live bus fields in IDLE so a zero-wait
    // request commits on its own sample edge, latched fields afterwards.
    always_comb begin
        acc_dad   = (state_q == IDLE) ? bus.DAD   : dad_q;
        acc_data  = (state_q == IDLE) ? DDT       : wdata_q;
        acc_size  = (state_q == IDLE) ? bus.SIZE  : size_q;
        acc_write = (state_q == IDLE) ? bus.WRITE : write_q;

        acc_off    = acc_dad - BASE;
        in_range   = (acc_off >> (ADDR_BITS + 2)) == '0;
        word_idx   = acc_off[ADDR_BITS+1:2];
        misaligned = ((acc_size == 2'b01) && acc_dad[0]) ||
                     (acc_size[1] && (acc_dad[1:0] != 2'b00));
        mem_word   = mem[word_idx];

        case (acc_size)
            2'b00: begin
                lane_en   = 4'b0001 << acc_dad[1:0];
                lane_data = {4{acc_data[7:0]}};
                rd_data   = {24'h0, mem_word[8*acc_dad[1:0] +: 8]};
            end
            2'b01: begin
                lane_en   = acc_dad[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{acc_data[15:0]}};
                rd_data   = {16'h0, (acc_dad[1] ? mem_word[31:16] : mem_word[15:0])};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = acc_data;
                rd_data   = mem_word;
            end
        endcase
        if (!in_range) begin
            rd_data = '0;
        end
    end

    // Next-state logic for the IDLE/WAIT/ACK sequencer and its registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dad_d     = dad_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        write_d   = write_q;
        rdata_d   = rdata_q;
        mis_d     = mis_q;
        rng_d     = rng_q;
        enter_ack = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.MREQ) begin
                    dad_d   = bus.DAD;
                    wdata_d = DDT;
                    size_d  = bus.SIZE;
                    write_d = bus.WRITE;
                    cnt_d   = 4'(WAIT_CYCLES);
                    mis_d   = mis_q | misaligned;
                    rng_d   = rng_q | ~in_range;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = ACK;
                    enter_ack = 1'b1;
                end
            end
            ACK: begin
                // MREQ is still high for the finished access here; never re-sample it.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ack_n_d = ~enter_ack;
        oe_d    = enter_ack & ~acc_write;
        if (enter_ack && !acc_write) begin
            rdata_d = rd_data;
        end
        commit = enter_ack & acc_write & in_range;
    end

    // Sequencer state, latched request and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dad_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            ack_n_q <= 1'b1;
            oe_q    <= 1'b0;
            mis_q   <= 1'b0;
            rng_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dad_q   <= dad_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            write_q <= write_d;
            ack_n_q <= ack_n_d;
            oe_q    <= oe_d;
            mis_q   <= mis_d;
            rng_q   <= rng_d;
        end
    end

    // Byte-enabled array write at the edge entering ACK; contents are never reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    assign bus.ACKD_n      = ack_n_q;
    assign bus.o_misalign  = mis_q;
    assign bus.o_range_err = rng_q;
    assign DDT             = oe_q ? rdata_q : 'z;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: one instance with two wait states for functional and
// timing checks, one zero-wait instance for back-to-back requests. Expected
// data comes from a word-level memory model built from the lane rules.
module tb_dmem_ctrl;
    localparam int unsigned W2    = 2;
    localparam logic [31:0] BASE2 = 32'h0001_0000;
    localparam int unsigned AB2   = 14;
    localparam int unsigned DEPTH2 = 1 << AB2;
    localparam logic [31:0] BASE0 = 32'h0002_0000;
    localparam int unsigned AB0   = 6;

    logic clk;
    logic rst_n;

    int checks;
    int fails;

    dmem_ctrl_if bus2();
    dmem_ctrl_if bus0();

    wire  [31:0] ddt2;
    wire  [31:0] ddt0;
    logic [31:0] tb_wd2, tb_wd0;
    logic        tb_oe2, tb_oe0;

    assign ddt2 = tb_oe2 ? tb_wd2 : 'z;
    assign ddt0 = tb_oe0 ? tb_wd0 : 'z;

    dmem_ctrl #(.ADDR_BITS(AB2), .BASE(BASE2), .WAIT_CYCLES(W2)) dut2 (
        .clk(clk), .rst(rst_n), .bus(bus2), .DDT(ddt2)
    );

    dmem_ctrl #(.ADDR_BITS(AB0), .BASE(BASE0), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst_n), .bus(bus0), .DDT(ddt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference memory for dut2: word index -> 32-bit contents.
    logic [31:0] model2 [int unsigned];

    function automatic bit in_win2(input logic [31:0] a);
        logic [63:0] aa, lo, hi;
        aa = {32'h0, a};
        lo = {32'h0, BASE2};
        hi = lo + 64'(4 * DEPTH2);
        return (aa >= lo) && (aa < hi);
    endfunction

    function automatic void model_store2(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int unsigned idx, sh;
        logic [31:0] w;
        if (!in_win2(a)) return;
        idx = (a - BASE2) / 4;
        w = model2.exists(idx) ? model2[idx] : 32'h0;
        if (sz == 2'b00) begin
            sh = (a % 4) * 8;
            w = (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        end else if (sz == 2'b01) begin
            sh = ((a % 4) / 2) * 16;
            w = (w & ~(32'hFFFF << sh)) | ((d & 32'hFFFF) << sh);
        end else begin
            w = d;
        end
        model2[idx] = w;
    endfunction

    function automatic logic [31:0] model_load2(input logic [1:0] sz, input logic [31:0] a);
        int unsigned idx, sh;
        logic [31:0] w;
        if (!in_win2(a)) return 32'h0;
        idx = (a - BASE2) / 4;
        w = model2.exists(idx) ? model2[idx] : 32'h0;
        if (sz == 2'b00) begin
            sh = (a % 4) * 8;
            return (w >> sh) & 32'hFF;
        end else if (sz == 2'b01) begin
            sh = ((a % 4) / 2) * 16;
            return (w >> sh) & 32'hFFFF;
        end
        return w;
    endfunction

    // One access on dut2. pat[n] is ACKD_n sampled 1 time unit after the
    // n-th edge counted from the sample edge E (n = 0). Bus fields are
    // scrambled right after E to show the access uses its latched copy.
    task automatic access2(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic [7:0] pat, output logic mis_e, output logic rng_e);
        rd = '0; pat = '1; mis_e = 1'b0; rng_e = 1'b0;
        bus2.MREQ = 1'b1; bus2.WRITE = wr; bus2.SIZE = sz; bus2.DAD = a;
        tb_wd2 = wd; tb_oe2 = wr;
        for (int unsigned n = 0; n <= W2 + 1; n++) begin
            @(posedge clk); #1;
            if (n == 0) begin
                mis_e = bus2.o_misalign;
                rng_e = bus2.o_range_err;
                bus2.DAD  = $urandom;
                bus2.SIZE = 2'($urandom);
                tb_wd2    = $urandom;
            end
            pat[n] = bus2.ACKD_n;
            if (n == W2) rd = ddt2;
        end
        bus2.MREQ = 1'b0; tb_oe2 = 1'b0;
    endtask

    function automatic logic [7:0] exp_pat();
        return 8'hFF ^ (8'h01 << W2);
    endfunction

    task automatic test_reset();
        checks++; if (bus2.ACKD_n !== 1'b1) begin fails++; $display("FAIL reset_ack2: got %b expected 1", bus2.ACKD_n); end
        checks++; if (bus2.o_misalign !== 1'b0) begin fails++; $display("FAIL reset_mis2: got %b expected 0", bus2.o_misalign); end
        checks++; if (bus2.o_range_err !== 1'b0) begin fails++; $display("FAIL reset_rng2: got %b expected 0", bus2.o_range_err); end
        checks++; if (bus0.ACKD_n !== 1'b1) begin fails++; $display("FAIL reset_ack0: got %b expected 1", bus0.ACKD_n); end
        checks++; if (bus0.o_misalign !== 1'b0) begin fails++; $display("FAIL reset_mis0: got %b expected 0", bus0.o_misalign); end
        checks++; if (bus0.o_range_err !== 1'b0) begin fails++; $display("FAIL reset_rng0: got %b expected 0", bus0.o_range_err); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic [7:0] pat; logic me, re;
        access2(1'b1, 2'b10, BASE2 + 8, 32'hDEADBEEF, rd, pat, me, re);
        model_store2(2'b10, BASE2 + 8, 32'hDEADBEEF);
        checks++; if (pat !== exp_pat()) begin fails++; $display("FAIL sw_ack_timing: got %h expected %h", pat, exp_pat()); end
        access2(1'b0, 2'b10, BASE2 + 8, 32'h0, rd, pat, me, re);
        checks++; if (pat !== exp_pat()) begin fails++; $display("FAIL lw_ack_timing: got %h expected %h", pat, exp_pat()); end
        checks++; if (rd !== model_load2(2'b10, BASE2 + 8)) begin fails++; $display("FAIL lw_data: got %h expected %h", rd, model_load2(2'b10, BASE2 + 8)); end
    endtask

    typedef struct { logic wr; logic [1:0] sz; logic [31:0] off; logic [31:0] d; } op_t;

    task automatic test_lanes();
        op_t ops[4];
        logic [31:0] rd, a; logic [7:0] pat; logic me, re;
        ops[0] = '{1'b1, 2'b00, 32'd9,  32'hFFFF_FF55};
        ops[1] = '{1'b0, 2'b10, 32'd8,  32'h0};
        ops[2] = '{1'b0, 2'b00, 32'd11, 32'h0};
        ops[3] = '{1'b0, 2'b01, 32'd10, 32'h0};
        foreach (ops[i]) begin
            a = BASE2 + ops[i].off;
            access2(ops[i].wr, ops[i].sz, a, ops[i].d, rd, pat, me, re);
            checks++; if (pat !== exp_pat()) begin fails++; $display("FAIL lanes_timing[%0d]: got %h expected %h", i, pat, exp_pat()); end
            if (ops[i].wr) begin
                model_store2(ops[i].sz, a, ops[i].d);
            end else begin
                checks++; if (rd !== model_load2(ops[i].sz, a)) begin fails++; $display("FAIL lanes_data[%0d]: got %h expected %h", i, rd, model_load2(ops[i].sz, a)); end
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d; logic [7:0] pat; logic me, re, wr; logic [1:0] sz;
        for (int unsigned i = 0; i < 16; i++) begin
            if (i == 2) continue;
            d = $urandom;
            access2(1'b1, 2'b10, BASE2 + 4 * i, d, rd, pat, me, re);
            model_store2(2'b10, BASE2 + 4 * i, d);
            checks++; if (pat !== exp_pat()) begin fails++; $display("FAIL init_timing[%0d]: got %h expected %h", i, pat, exp_pat()); end
        end
        for (int unsigned i = 0; i < 40; i++) begin
            wr = 1'($urandom);
            sz = 2'($urandom);
            a  = BASE2 + 4 * ($urandom % 16);
            if (sz == 2'b00) a = a + ($urandom % 4);
            else if (sz == 2'b01) a = a + 2 * ($urandom % 2);
            d = $urandom;
            access2(wr, sz, a, d, rd, pat, me, re);
            checks++; if (pat !== exp_pat()) begin fails++; $display("FAIL rand_timing[%0d]: got %h expected %h", i, pat, exp_pat()); end
            if (wr) model_store2(sz, a, d);
            else begin
                checks++; if (rd !== model_load2(sz, a)) begin fails++; $display("FAIL rand_data[%0d] sz=%0d a=%h: got %h expected %h", i, sz, a, rd, model_load2(sz, a)); end
            end
        end
        checks++; if (bus2.o_misalign !== 1'b0) begin fails++; $display("FAIL rand_no_mis: got %b expected 0", bus2.o_misalign); end
        checks++; if (bus2.o_range_err !== 1'b0) begin fails++; $display("FAIL rand_no_rng: got %b expected 0", bus2.o_range_err); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic [7:0] pat; logic me, re;
        access2(1'b0, 2'b10, BASE2 + 10, 32'h0, rd, pat, me, re);
        checks++; if (rd !== model_load2(2'b10, BASE2 + 8)) begin fails++; $display("FAIL mis_data: got %h expected %h", rd, model_load2(2'b10, BASE2 + 8)); end
        checks++; if (me !== 1'b1) begin fails++; $display("FAIL mis_at_sample: got %b expected 1", me); end
        access2(1'b0, 2'b01, BASE2 + 5, 32'h0, rd, pat, me, re);
        checks++; if (rd !== model_load2(2'b01, BASE2 + 5)) begin fails++; $display("FAIL mis_half_data: got %h expected %h", rd, model_load2(2'b01, BASE2 + 5)); end
        access2(1'b0, 2'b00, BASE2 + 4, 32'h0, rd, pat, me, re);
        checks++; if (bus2.o_misalign !== 1'b1) begin fails++; $display("FAIL mis_sticky: got %b expected 1", bus2.o_misalign); end
        checks++; if (re !== 1'b0) begin fails++; $display("FAIL mis_no_rng: got %b expected 0", re); end
    endtask

    task automatic test_range();
        logic [31:0] rd, d, last; logic [7:0] pat; logic me, re;
        last = BASE2 + 4 * (DEPTH2 - 1);
        d = $urandom;
        access2(1'b1, 2'b10, last, d, rd, pat, me, re);
        model_store2(2'b10, last, d);
        access2(1'b1, 2'b10, BASE2 - 4, 32'hCAFEF00D, rd, pat, me, re);
        model_store2(2'b10, BASE2 - 4, 32'hCAFEF00D);
        checks++; if (pat !== exp_pat()) begin fails++; $display("FAIL rng_sw_timing: got %h expected %h", pat, exp_pat()); end
        checks++; if (re !== 1'b1) begin fails++; $display("FAIL rng_at_sample: got %b expected 1", re); end
        access2(1'b0, 2'b10, last, 32'h0, rd, pat, me, re);
        checks++; if (rd !== model_load2(2'b10, last)) begin fails++; $display("FAIL rng_last_intact: got %h expected %h", rd, model_load2(2'b10, last)); end
        access2(1'b0, 2'b10, BASE2 - 4, 32'h0, rd, pat, me, re);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL rng_lw_below: got %h expected 00000000", rd); end
        checks++; if (pat !== exp_pat()) begin fails++; $display("FAIL rng_lw_timing: got %h expected %h", pat, exp_pat()); end
        access2(1'b0, 2'b10, BASE2 + 4 * DEPTH2, 32'h0, rd, pat, me, re);
        checks++; if (rd !== 32'h0) begin fails++; $display("FAIL rng_lw_above: got %h expected 00000000", rd); end
        access2(1'b0, 2'b10, BASE2, 32'h0, rd, pat, me, re);
        checks++; if (rd !== model_load2(2'b10, BASE2)) begin fails++; $display("FAIL rng_word0_intact: got %h expected %h", rd, model_load2(2'b10, BASE2)); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd; logic [7:0] pat; logic me, re; logic ack_ok;
        bus2.MREQ = 1'b1; bus2.WRITE = 1'b1; bus2.SIZE = 2'b10; bus2.DAD = BASE2;
        tb_wd2 = 32'h12345678; tb_oe2 = 1'b1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        bus2.MREQ = 1'b0; tb_oe2 = 1'b0;
        #1;
        checks++; if (bus2.ACKD_n !== 1'b1) begin fails++; $display("FAIL rstw_ack_now: got %b expected 1", bus2.ACKD_n); end
        checks++; if (bus2.o_misalign !== 1'b0) begin fails++; $display("FAIL rstw_mis_clear: got %b expected 0", bus2.o_misalign); end
        checks++; if (bus2.o_range_err !== 1'b0) begin fails++; $display("FAIL rstw_rng_clear: got %b expected 0", bus2.o_range_err); end
        ack_ok = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus2.ACKD_n !== 1'b1) ack_ok = 1'b0;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus2.ACKD_n !== 1'b1) ack_ok = 1'b0;
        end
        checks++; if (ack_ok !== 1'b1) begin fails++; $display("FAIL rstw_no_ack: got %b expected 1", ack_ok); end
        access2(1'b0, 2'b10, BASE2, 32'h0, rd, pat, me, re);
        checks++; if (rd !== model_load2(2'b10, BASE2)) begin fails++; $display("FAIL rstw_prior_data: got %h expected %h", rd, model_load2(2'b10, BASE2)); end
        checks++; if (pat !== exp_pat()) begin fails++; $display("FAIL rstw_lw_timing: got %h expected %h", pat, exp_pat()); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd [6];
        int unsigned idx, acks;
        logic low, pat_ok;
        foreach (wd[i]) wd[i] = $urandom;
        for (int unsigned pass = 0; pass < 2; pass++) begin
            idx = 0; acks = 0; pat_ok = 1'b1;
            bus0.MREQ = 1'b1; bus0.WRITE = (pass == 0); bus0.SIZE = 2'b10; bus0.DAD = BASE0;
            tb_wd0 = wd[0]; tb_oe0 = (pass == 0);
            for (int unsigned k = 1; k <= 13; k++) begin
                @(posedge clk); #1;
                low = ~bus0.ACKD_n;
                if (low != ((k % 2) == 1 && k <= 11)) pat_ok = 1'b0;
                if (low) begin
                    if (pass == 1 && idx < 6) begin
                        checks++; if (ddt0 !== wd[idx]) begin fails++; $display("FAIL b2b_data[%0d]: got %h expected %h", idx, ddt0, wd[idx]); end
                    end
                    acks++; idx++;
                    if (idx < 6) begin
                        bus0.DAD = BASE0 + 4 * idx;
                        tb_wd0 = wd[idx];
                    end
                end
                if (k == 12) begin bus0.MREQ = 1'b0; tb_oe0 = 1'b0; end
            end
            checks++; if (pat_ok !== 1'b1) begin fails++; $display("FAIL b2b_ack_every2[%0d]: got %b expected 1", pass, pat_ok); end
            checks++; if (acks != 6) begin fails++; $display("FAIL b2b_ack_count[%0d]: got %0d expected 6", pass, acks); end
        end
    endtask

    initial begin
        checks = 0; fails = 0;
        rst_n = 1'b0;
        bus2.MREQ = 1'b0; bus2.WRITE = 1'b0; bus2.SIZE = 2'b00; bus2.DAD = '0;
        bus0.MREQ = 1'b0; bus0.WRITE = 1'b0; bus0.SIZE = 2'b00; bus0.DAD = '0;
        tb_wd2 = '0; tb_oe2 = 1'b0; tb_wd0 = '0; tb_oe0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        test_write_read();
        test_lanes();
        test_random();
        test_misalign();
        test_range();
        test_reset_mid_wait();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
